// File: rtl/kbd_input_controller.sv
// PS/2 keyboard input controller: scan-code prefix FSM, Shift/Caps tracking
// and a show-ahead character FIFO for the processor's MMIO port.
module kbd_input_controller #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic             scan_done_tick,
  input  logic [7:0]       scan_code,
  input  logic [7:0]       ascii_in,
  output logic             letter_case,
  input  logic             rd_en,
  output logic [7:0]       rd_data,
  output logic             data_valid,
  output logic [PTR_W:0]   fifo_count,
  output logic             overflow,
  input  logic             clr_overflow
);

  localparam logic [7:0] C_EXT   = 8'hE0;
  localparam logic [7:0] C_BRK   = 8'hF0;
  localparam logic [7:0] C_LSHFT = 8'h12;
  localparam logic [7:0] C_RSHFT = 8'h59;
  localparam logic [7:0] C_CAPS  = 8'h58;

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BRK,
    S_EXT,
    S_EXT_BRK
  } state_e;

  state_e state_q, state_d;

  logic shl_q, shl_d;
  logic shr_q, shr_d;
  logic caps_q, caps_d;
  logic lc_q;
  logic push_req;

  logic [7:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic ovf_q, ovf_d;

  logic is_ext, is_brk, is_lsh, is_rsh, is_caps;
  logic empty, full;
  logic do_push, do_pop, drop;

  assign is_ext  = (scan_code == C_EXT);
  assign is_brk  = (scan_code == C_BRK);
  assign is_lsh  = (scan_code == C_LSHFT);
  assign is_rsh  = (scan_code == C_RSHFT);
  assign is_caps = (scan_code == C_CAPS);

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      shl_q   <= 1'b0;
      shr_q   <= 1'b0;
      caps_q  <= 1'b0;
      lc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      shl_q   <= shl_d;
      shr_q   <= shr_d;
      caps_q  <= caps_d;
      lc_q    <= (shl_d | shr_d) ^ caps_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shl_d    = shl_q;
    shr_d    = shr_q;
    caps_d   = caps_q;
    push_req = 1'b0;
    if (scan_done_tick) begin
      unique case (state_q)
        S_IDLE: begin
          unique case (1'b1)
            is_ext:  state_d = S_EXT;
            is_brk:  state_d = S_BRK;
            is_lsh:  shl_d   = 1'b1;
            is_rsh:  shr_d   = 1'b1;
            is_caps: caps_d  = ~caps_q;
            default: push_req = (ascii_in != 8'h00);
          endcase
        end
        S_BRK: begin
          state_d = S_IDLE;
          if (is_lsh) shl_d = 1'b0;
          if (is_rsh) shr_d = 1'b0;
        end
        S_EXT: begin
          state_d = is_brk ? S_EXT_BRK : S_IDLE;
        end
        S_EXT_BRK: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == FULL_CNT);

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push
  assign do_pop  = rd_en & ~empty;
  assign do_push = push_req & (~full | do_pop);
  assign drop    = push_req & full & ~do_pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clr_overflow) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge sysclk) begin
    if (do_push) mem_q[wr_ptr_q] <= ascii_in;
  end

  assign letter_case = lc_q;
  assign rd_data     = empty ? 8'h00 : mem_q[rd_ptr_q];
  assign data_valid  = ~empty;
  assign fifo_count  = cnt_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_kbd_input_controller.sv
// Bench for kbd_input_controller: scoreboard of expected characters,
// popped and compared as the processor side reads the FIFO.
module tb_kbd_input_controller;

  logic       sysclk = 1'b0;
  logic       reset;
  logic       scan_done_tick;
  logic [7:0] scan_code;
  logic [7:0] ascii_in;
  logic       letter_case;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       data_valid;
  logic [3:0] fifo_count;
  logic       overflow;
  logic       clr_overflow;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q [$];

  kbd_input_controller #(.DEPTH(8), .PTR_W(3)) dut (
    .sysclk        (sysclk),
    .reset         (reset),
    .scan_done_tick(scan_done_tick),
    .scan_code     (scan_code),
    .ascii_in      (ascii_in),
    .letter_case   (letter_case),
    .rd_en         (rd_en),
    .rd_data       (rd_data),
    .data_valid    (data_valid),
    .fifo_count    (fifo_count),
    .overflow      (overflow),
    .clr_overflow  (clr_overflow)
  );

  always #5 sysclk = ~sysclk;

  function automatic logic [7:0] lut(input logic [7:0] c, input logic up);
    case (c)
      8'h1C:   return up ? 8'h41 : 8'h61;
      8'h32:   return up ? 8'h42 : 8'h62;
      default: return 8'h00;
    endcase
  endfunction

  assign ascii_in = lut(scan_code, letter_case);

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge sysclk);
    #1;
  endtask

  task automatic tick(input logic [7:0] c, input logic rd = 1'b0,
                      input logic clr = 1'b0);
    scan_code      = c;
    scan_done_tick = 1'b1;
    rd_en          = rd;
    clr_overflow   = clr;
    cyc();
    scan_done_tick = 1'b0;
    rd_en          = 1'b0;
    clr_overflow   = 1'b0;
  endtask

  // Make code that is expected to land in the FIFO as ch
  task automatic key(input logic [7:0] c, input logic [7:0] ch);
    exp_q.push_back(ch);
    tick(c);
  endtask

  task automatic pop_one(input string tag);
    logic [7:0] e;
    e = exp_q.pop_front();
    chk({tag, "_head"}, rd_data, e);
    rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
  endtask

  task automatic drain(input string tag);
    int guard;
    guard = 0;
    chk({tag, "_cnt"}, fifo_count, exp_q.size());
    while (exp_q.size() > 0 && guard < 32) begin
      chk({tag, "_dv"}, data_valid, 1'b1);
      pop_one(tag);
      guard++;
    end
    chk({tag, "_empty_dv"}, data_valid, 1'b0);
    chk({tag, "_empty_rd"}, rd_data, 8'h00);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_dv"}, data_valid, 1'b0);
    chk({tag, "_rd"}, rd_data, 8'h00);
    chk({tag, "_cnt"}, fifo_count, 4'd0);
    chk({tag, "_ovf"}, overflow, 1'b0);
    chk({tag, "_lc"}, letter_case, 1'b0);
  endtask

  initial begin
    reset          = 1'b1;
    scan_done_tick = 1'b0;
    scan_code      = 8'h00;
    rd_en          = 1'b0;
    clr_overflow   = 1'b0;
    repeat (3) cyc();
    chk_reset("rst_hold");
    reset = 1'b0;
    cyc();
    chk_reset("rst");

    // basic make, push latency and pop
    key(8'h1C, 8'h61);
    chk("t1_dv", data_valid, 1'b1);
    chk("t1_rd", rd_data, 8'h61);
    chk("t1_cnt", fifo_count, 4'd1);
    pop_one("t1");
    chk("t1_dv0", data_valid, 1'b0);
    chk("t1_rd0", rd_data, 8'h00);
    pop_one_empty_check();

    // shift held, break pair, shift released
    tick(8'h12);
    chk("t2_lc1", letter_case, 1'b1);
    key(8'h1C, 8'h41);
    tick(8'hF0);
    tick(8'h1C);
    tick(8'hF0);
    tick(8'h12);
    chk("t2_lc0", letter_case, 1'b0);
    key(8'h1C, 8'h61);
    chk("t2_cnt", fifo_count, 4'd2);
    drain("t2");

    // caps lock with shift
    tick(8'h58);
    chk("t3_caps", letter_case, 1'b1);
    tick(8'hF0);
    tick(8'h58);
    tick(8'h12);
    chk("t3_lc0", letter_case, 1'b0);
    key(8'h1C, 8'h61);
    tick(8'hF0);
    tick(8'h12);
    chk("t3_lc1", letter_case, 1'b1);
    key(8'h1C, 8'h41);
    key(8'h32, 8'h42);
    drain("t3");
    tick(8'h58);
    tick(8'hF0);
    tick(8'h58);
    chk("t3_caps_off", letter_case, 1'b0);

    // extended arrow key: nothing pushed
    tick(8'hE0);
    tick(8'h75);
    tick(8'hE0);
    tick(8'hF0);
    tick(8'h75);
    chk("t4_cnt0", fifo_count, 4'd0);
    tick(8'h75);
    chk("t4_unmapped", fifo_count, 4'd0);
    key(8'h1C, 8'h61);
    drain("t4");

    // fill, overflow, simultaneous push/pop when full
    for (int i = 0; i < 8; i++) key(8'h1C, 8'h61);
    chk("t5_full_ovf0", overflow, 1'b0);
    tick(8'h32);
    chk("t5_cnt8", fifo_count, 4'd8);
    chk("t5_ovf1", overflow, 1'b1);
    chk("t5_head", rd_data, exp_q[0]);
    void'(exp_q.pop_front());
    exp_q.push_back(8'h62);
    tick(8'h32, 1'b1);
    chk("t5_pp_cnt", fifo_count, 4'd8);
    tick(8'h32, 1'b0, 1'b1);
    chk("t5_setwins", overflow, 1'b1);
    clr_overflow = 1'b1;
    cyc();
    clr_overflow = 1'b0;
    chk("t5_clr", overflow, 1'b0);
    drain("t5");

    // push and pop together on empty FIFO
    exp_q.push_back(8'h62);
    tick(8'h32, 1'b1);
    chk("t6_cnt1", fifo_count, 4'd1);
    drain("t6");

    // reset mid-sequence
    tick(8'h1C);
    tick(8'h1C);
    tick(8'h1C);
    chk("t7_cnt3", fifo_count, 4'd3);
    tick(8'hF0);
    reset = 1'b1;
    #2;
    chk_reset("t7_async");
    cyc();
    reset = 1'b0;
    cyc();
    chk_reset("t7_rst");
    key(8'h1C, 8'h61);
    chk("t7_cnt1", fifo_count, 4'd1);
    drain("t7");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // rd_en while empty must leave the FIFO untouched
  task automatic pop_one_empty_check();
    rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
    chk("empty_pop_cnt", fifo_count, 4'd0);
    chk("empty_pop_dv", data_valid, 1'b0);
  endtask

endmodule

// File: doc/kbd_input_controller.md
Name: kbd_input_controller

Overview:
- Sequences the PS/2 keyboard datapath: consumes raw scan-code ticks from the PS/2 receiver and decodes the make/break/extended prefix protocol.
- Tracks Shift and Caps Lock, and drives the case select of the scan-to-ASCII lookup.
- Buffers resulting ASCII characters in a show-ahead FIFO, read by the processor's memory-mapped I/O port, so no keystroke is lost between processor polls.

Parameters:
- DEPTH, 8, FIFO entries; must be a power of 2, minimum 2.
- PTR_W, 3, log2(DEPTH); count width is PTR_W+1.

Ports:
- sysclk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- scan_done_tick  in  1  one-sysclk pulse; scan_code valid this cycle.
- scan_code  in  8  byte from the PS/2 receiver.
- ascii_in  in  8  combinational result of the ASCII lookup for scan_code at letter_case; 0x00 means unmapped.
- letter_case  out  1  to the lookup; 1 = uppercase table; equals shift_held XOR caps_lock.
- rd_en  in  1  processor pop request, one cycle per pop.
- rd_data  out  8  FIFO head; 0x00 when empty.
- data_valid  out  1  FIFO non-empty.
- fifo_count  out  PTR_W+1  entries held, 0..DEPTH.
- overflow  out  1  sticky flag; a character was dropped because the FIFO was full.
- clr_overflow  in  1  clears overflow.

Behaviour:
- Reset (async) values:
  - FSM in IDLE; shift_l, shift_r and caps_lock = 0.
  - FIFO pointers = 0, fifo_count = 0.
  - data_valid = 0, rd_data = 0x00, overflow = 0, letter_case = 0.
  - Reset mid-sequence discards any partial prefix and all buffered data.
- Scope of FSM: the FSM advances only on cycles where scan_done_tick = 1.
- FSM transitions, all on scan_done_tick:
  - IDLE: 0xE0 -> EXT; 0xF0 -> BRK. Any other code is a make code: stay IDLE and process it.
  - BRK: any code -> IDLE. 0x12 clears shift_l; 0x59 clears shift_r; all other codes are ignored (no push).
  - EXT: 0xF0 -> EXT_BRK; any other code -> IDLE, discarded (no push).
  - EXT_BRK: any code -> IDLE, discarded.
  - A stray 0xE0 or 0xF0 received in BRK or EXT_BRK is consumed as the key byte and returns the FSM to IDLE.
- Make-code processing in IDLE:
  - 0x12 sets shift_l; 0x59 sets shift_r.
  - 0x58 toggles caps_lock; a typematic repeat toggles again.
  - Any other code: push ascii_in when ascii_in != 0x00, otherwise drop silently.
  - Typematic repeats of a normal key push again.
- letter_case is registered from the modifier state. A modifier change takes effect for the next tick, never for the tick that changed it.
- Push latency: ascii_in is sampled in the tick cycle. The entry is visible on rd_data, data_valid and fifo_count on the following cycle.
- FIFO is show-ahead: rd_data always presents the head entry.
  - rd_en with data_valid = 1 advances the head; the new head (or 0x00 if now empty) is visible the next cycle.
  - rd_en while empty is ignored.
  - Pointers wrap modulo DEPTH.
- Full FIFO:
  - A push with no simultaneous pop is dropped, and overflow is set the next cycle.
  - Push and pop in the same cycle while full are both accepted; count stays DEPTH.
  - Push and pop in the same cycle while empty: push accepted, pop ignored; count becomes 1.
  - Push and pop in the same cycle otherwise: both accepted; count unchanged.
- overflow stays set until clr_overflow. If clr_overflow and a new drop occur in the same cycle, set wins.

Test Plan:
- Reset, then tick 0x1C -> ascii 'a' 0x61 is pushed; next cycle data_valid = 1, rd_data = 0x61, fifo_count = 1. rd_en pulse -> data_valid = 0, rd_data = 0x00.
- Ticks 0x12, 0x1C, 0xF0, 0x1C, 0xF0, 0x12, 0x1C:
  - letter_case = 1 before the second tick; pushes 0x41.
  - The break pair of 0x1C pushes nothing.
  - After 0xF0 0x12, letter_case = 0; the final 0x1C pushes 0x61.
  - fifo_count = 2.
- Ticks 0x58, 0xF0, 0x58, 0x12, 0x1C (caps on, shift held) -> letter_case = 0; pushes 0x61. Ticks 0xF0, 0x12, 0x1C -> letter_case = 1; pushes 0x41.
- Ticks 0xE0, 0x75, 0xE0, 0xF0, 0x75 (arrow key) -> no push; FSM back in IDLE. A following 0x1C pushes 0x61.
- DEPTH = 8, nine 0x1C make ticks with no reads:
  - fifo_count = 8, overflow = 1.
  - rd_en on the same cycle as a tenth tick -> count stays 8.
  - clr_overflow -> overflow = 0.
- Push three characters, send tick 0xF0, then assert reset -> all outputs return to reset values. A following 0x1C is treated as a make and pushes 0x61.
